flip_stream: RTL and testbench

Streaming, parametrised Othello flip engine. It accepts LANES independent (player, opponent, pos) requests per beat over a valid/ready handshake. For each lane it returns:
- the 64-bit flip mask across all 8 directions,
- a legality flag,
- an occupied flag,
- the post-move board.

It sits between the move generator and the search tree-update logic, as the pipelined, back-pressurable successor of the single-request fixed-latency flip unit.

---
 rtl/othello_pkg.sv | 101 ++++++++++
 rtl/flip_line.sv | 50 +++++
 rtl/flip_stream.sv | 177 +++++++++++++++++
 tb/tb_flip_stream.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/othello_pkg.sv
// Shared types and line helpers for the Othello flip engine.
// A "line" is the 8 squares through a move square along one direction.
package othello_pkg;

    localparam int BOARD_W = 64;
    localparam int LINE_W  = 8;
    localparam int POS_W   = 6;
    localparam int N_DIR   = 4;

    typedef enum logic [1:0] {
        DIR_H,
        DIR_V,
        DIR_A1H8,
        DIR_A8H1
    } dir_e;

    // One lane's request, opponent already normalised
    typedef struct packed {
        logic               en;
        logic [BOARD_W-1:0] pl;
        logic [BOARD_W-1:0] op;
        logic [POS_W-1:0]   pos;
    } req_t;

    // Request plus its four extracted lines
    typedef struct packed {
        req_t                          req;
        logic [N_DIR-1:0][LINE_W-1:0]  pl;
        logic [N_DIR-1:0][LINE_W-1:0]  ol;
    } line_t;

    // Request plus the per-line flip results
    typedef struct packed {
        req_t                          req;
        logic [N_DIR-1:0][LINE_W-1:0]  fl;
    } fl_t;

    // Final per-lane result
    typedef struct packed {
        logic               en;
        logic               legal;
        logic               occ;
        logic [BOARD_W-1:0] flip;
        logic [BOARD_W-1:0] pl;
        logic [BOARD_W-1:0] op;
    } res_t;

    // Index of the move square inside its line
    function automatic logic [2:0] line_idx(dir_e d, logic [POS_W-1:0] pos);
        return (d == DIR_H) ? pos[2:0] : pos[5:3];
    endfunction

    // Board square of line element i: {on_board, square}
    // Diagonal lines are indexed by row; off-board columns are flagged.
    function automatic logic [6:0] line_sq(dir_e d, logic [POS_W-1:0] pos,
                                           logic [2:0] i);
        logic [4:0] t;
        logic [6:0] s;
        t = '0;
        s = '0;
        unique case (d)
            DIR_H: s = {1'b1, pos[5:3], i};
            DIR_V: s = {1'b1, i, pos[2:0]};
            DIR_A1H8: begin
                t = 5'(i) + 5'(pos[2:0]) - 5'(pos[5:3]);
                s = {(t[4:3] == 2'b00), i, t[2:0]};
            end
            DIR_A8H1: begin
                t = 5'(pos[5:3]) + 5'(pos[2:0]) - 5'(i);
                s = {(t[4:3] == 2'b00), i, t[2:0]};
            end
            default: s = '0;
        endcase
        return s;
    endfunction

    function automatic logic [LINE_W-1:0] extract_line(
        logic [BOARD_W-1:0] b, dir_e d, logic [POS_W-1:0] pos);
        logic [LINE_W-1:0] l;
        logic [6:0]        s;
        l = '0;
        for (int i = 0; i < LINE_W; i++) begin
            s    = line_sq(d, pos, 3'(i));
            l[i] = s[6] & b[s[5:0]];
        end
        return l;
    endfunction

    function automatic logic [BOARD_W-1:0] scatter_line(
        logic [LINE_W-1:0] l, dir_e d, logic [POS_W-1:0] pos);
        logic [BOARD_W-1:0] b;
        logic [6:0]         s;
        b = '0;
        for (int i = 0; i < LINE_W; i++) begin
            s         = line_sq(d, pos, 3'(i));
            b[s[5:0]] = b[s[5:0]] | (s[6] & l[i]);
        end
        return b;
    endfunction

endpackage

// File: rtl/flip_line.sv
// Two-sided flip along one 8-square line.
// A run of opponent discs flips only when closed by a player disc.
module flip_line
    import othello_pkg::*;
(
    input  logic [LINE_W-1:0] player_i,
    input  logic [LINE_W-1:0] opponent_i,
    input  logic [2:0]        pos_i,
    output logic [LINE_W-1:0] flip_o
);

    logic [LINE_W-1:0] run_up;
    logic [LINE_W-1:0] run_dn;
    logic              go_up;
    logic              go_dn;
    logic [3:0]        up;
    logic [3:0]        dn;

    // Walk outward on both sides; bit 3 of the index marks leaving the line
    always_comb begin
        flip_o = '0;
        run_up = '0;
        run_dn = '0;
        go_up  = 1'b1;
        go_dn  = 1'b1;
        up     = '0;
        dn     = '0;
        for (int i = 1; i < LINE_W; i++) begin
            up = {1'b0, pos_i} + 4'(i);
            dn = {1'b0, pos_i} - 4'(i);
            if (go_up && !up[3]) begin
                if (opponent_i[up[2:0]]) begin
                    run_up[up[2:0]] = 1'b1;
                end else begin
                    if (player_i[up[2:0]]) flip_o = flip_o | run_up;
                    go_up = 1'b0;
                end
            end
            if (go_dn && !dn[3]) begin
                if (opponent_i[dn[2:0]]) begin
                    run_dn[dn[2:0]] = 1'b1;
                end else begin
                    if (player_i[dn[2:0]]) flip_o = flip_o | run_dn;
                    go_dn = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/flip_stream.sv
// Pipelined multi-lane Othello flip engine with a global stall.
// Capture, line flip, line flip register, then scatter into the result.
module flip_stream
    import othello_pkg::*;
#(
    parameter int LANES = 1,
    parameter int TAG_W = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES-1:0]       in_lane_en,
    input  logic [64*LANES-1:0]    in_player,
    input  logic [64*LANES-1:0]    in_opponent,
    input  logic [6*LANES-1:0]     in_pos,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES-1:0]       out_lane_en,
    output logic [64*LANES-1:0]    out_flip,
    output logic [LANES-1:0]       out_legal,
    output logic [LANES-1:0]       out_occupied,
    output logic [64*LANES-1:0]    out_player,
    output logic [64*LANES-1:0]    out_opponent,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   busy
);

    logic advance;

    logic s0_v_q;
    logic s1_v_q;
    logic s2_v_q;
    logic out_v_q;

    logic [TAG_W-1:0] s0_tag_q;
    logic [TAG_W-1:0] s1_tag_q;
    logic [TAG_W-1:0] s2_tag_q;
    logic [TAG_W-1:0] out_tag_q;

    req_t  [LANES-1:0] s0_d;
    req_t  [LANES-1:0] s0_q;
    line_t [LANES-1:0] s1_d;
    line_t [LANES-1:0] s1_q;
    fl_t   [LANES-1:0] s2_d;
    fl_t   [LANES-1:0] s2_q;
    res_t  [LANES-1:0] out_d;
    res_t  [LANES-1:0] out_q;

    logic [LANES-1:0][N_DIR-1:0][LINE_W-1:0] fl_w;

    logic [BOARD_W-1:0] fl64;
    logic [BOARD_W-1:0] posbit;
    logic               occ;
    logic               legal;

    assign advance  = !out_v_q || out_ready;
    assign in_ready = advance && !reset;
    assign busy     = s0_v_q | s1_v_q | s2_v_q | out_v_q;
    assign out_valid = out_v_q;
    assign out_tag   = out_tag_q;

    // Capture: disabled lanes become all-zero, overlaps go to the player
    always_comb begin
        s0_d = '0;
        for (int k = 0; k < LANES; k++) begin
            if (in_lane_en[k]) begin
                s0_d[k].en  = 1'b1;
                s0_d[k].pl  = in_player[64*k +: 64];
                s0_d[k].op  = in_opponent[64*k +: 64]
                            & ~in_player[64*k +: 64];
                s0_d[k].pos = in_pos[6*k +: 6];
            end
        end
    end

    // Pull the four lines through the move square
    always_comb begin
        s1_d = '0;
        for (int k = 0; k < LANES; k++) begin
            s1_d[k].req = s0_q[k];
            for (int d = 0; d < N_DIR; d++) begin
                s1_d[k].pl[d] = extract_line(s0_q[k].pl,
                                             dir_e'(2'(d)), s0_q[k].pos);
                s1_d[k].ol[d] = extract_line(s0_q[k].op,
                                             dir_e'(2'(d)), s0_q[k].pos);
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        for (genvar d = 0; d < N_DIR; d++) begin : g_dir
            flip_line u_line (
                .player_i   (s1_q[k].pl[d]),
                .opponent_i (s1_q[k].ol[d]),
                .pos_i      (line_idx(dir_e'(2'(d)), s1_q[k].req.pos)),
                .flip_o     (fl_w[k][d])
            );
        end
        assign out_lane_en[k]         = out_q[k].en;
        assign out_legal[k]           = out_q[k].legal;
        assign out_occupied[k]        = out_q[k].occ;
        assign out_flip[64*k +: 64]     = out_q[k].flip;
        assign out_player[64*k +: 64]   = out_q[k].pl;
        assign out_opponent[64*k +: 64] = out_q[k].op;
    end

    // Carry the line flips alongside their request
    always_comb begin
        s2_d = '0;
        for (int k = 0; k < LANES; k++) begin
            s2_d[k].req = s1_q[k].req;
            s2_d[k].fl  = fl_w[k];
        end
    end

    // Scatter lines back to the board and form the next position
    always_comb begin
        out_d  = '0;
        fl64   = '0;
        posbit = '0;
        occ    = 1'b0;
        legal  = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            fl64 = '0;
            for (int d = 0; d < N_DIR; d++) begin
                fl64 = fl64 | scatter_line(s2_q[k].fl[d],
                                           dir_e'(2'(d)), s2_q[k].req.pos);
            end
            posbit = 64'd1 << s2_q[k].req.pos;
            occ    = |((s2_q[k].req.pl | s2_q[k].req.op) & posbit);
            if (occ) fl64 = '0;
            legal  = s2_q[k].req.en && !occ && (fl64 != '0);
            out_d[k].en    = s2_q[k].req.en;
            out_d[k].flip  = fl64;
            out_d[k].legal = legal;
            out_d[k].occ   = occ && s2_q[k].req.en;
            out_d[k].pl    = legal ? (s2_q[k].req.pl | fl64 | posbit)
                                   : s2_q[k].req.pl;
            out_d[k].op    = legal ? (s2_q[k].req.op & ~fl64)
                                   : s2_q[k].req.op;
        end
    end

    // Every stage shifts together whenever the output slot can move
    always_ff @(posedge clock) begin
        if (reset) begin
            s0_v_q    <= 1'b0;
            s1_v_q    <= 1'b0;
            s2_v_q    <= 1'b0;
            out_v_q   <= 1'b0;
            s0_tag_q  <= '0;
            s1_tag_q  <= '0;
            s2_tag_q  <= '0;
            out_tag_q <= '0;
            s0_q      <= '0;
            s1_q      <= '0;
            s2_q      <= '0;
            out_q     <= '0;
        end else if (advance) begin
            s0_v_q    <= in_valid;
            s0_tag_q  <= in_tag;
            s0_q      <= s0_d;
            s1_v_q    <= s0_v_q;
            s1_tag_q  <= s0_tag_q;
            s1_q      <= s1_d;
            s2_v_q    <= s1_v_q;
            s2_tag_q  <= s1_tag_q;
            s2_q      <= s2_d;
            out_v_q   <= s2_v_q;
            out_tag_q <= s2_tag_q;
            out_q     <= out_d;
        end
    end

endmodule

// File: tb/tb_flip_stream.sv
// Bench for flip_stream with two lanes: fixed vectors, backpressure,
// mid-stream reset and random traffic against a square-walking model.
module tb_flip_stream;

    localparam int L = 2;

    logic           clock = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [L-1:0]   in_lane_en;
    logic [64*L-1:0] in_player;
    logic [64*L-1:0] in_opponent;
    logic [6*L-1:0] in_pos;
    logic [7:0]     in_tag;
    logic           out_valid;
    logic           out_ready;
    logic [L-1:0]   out_lane_en;
    logic [64*L-1:0] out_flip;
    logic [L-1:0]   out_legal;
    logic [L-1:0]   out_occupied;
    logic [64*L-1:0] out_player;
    logic [64*L-1:0] out_opponent;
    logic [7:0]     out_tag;
    logic           busy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    flip_stream #(.LANES(L), .TAG_W(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_lane_en   (in_lane_en),
        .in_player    (in_player),
        .in_opponent  (in_opponent),
        .in_pos       (in_pos),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_lane_en  (out_lane_en),
        .out_flip     (out_flip),
        .out_legal    (out_legal),
        .out_occupied (out_occupied),
        .out_player   (out_player),
        .out_opponent (out_opponent),
        .out_tag      (out_tag),
        .busy         (busy)
    );

    typedef struct {
        logic [63:0] pl;
        logic [63:0] op;
        logic [5:0]  pos;
        logic [63:0] flip;
        logic        legal;
        logic        occ;
        logic [63:0] npl;
        logic [63:0] nop;
    } vec_t;

    typedef struct {
        logic [7:0]   tag;
        logic [1:0]   en;
        logic [127:0] pl;
        logic [127:0] op;
        logic [11:0]  pos;
    } in_beat_t;

    typedef struct {
        logic [7:0]   tag;
        logic [1:0]   en;
        logic [127:0] flip;
        logic [1:0]   legal;
        logic [1:0]   occ;
        logic [127:0] npl;
        logic [127:0] nop;
    } beat_t;

    beat_t exp_q[$];
    logic  mon_en = 1'b0;
    vec_t  vt[8];

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // Walk the eight compass directions square by square
    function automatic void ref_lane(
        input logic en, input logic [63:0] pl_in, input logic [63:0] op_in,
        input logic [5:0] pos, output logic [63:0] flip,
        output logic legal, output logic occ,
        output logic [63:0] npl, output logic [63:0] nop);
        logic [63:0] pl, op, run;
        int r, c, rr, cc;
        flip = '0; legal = 1'b0; occ = 1'b0; npl = '0; nop = '0;
        if (!en) return;
        pl = pl_in;
        op = op_in & ~pl_in;
        r = int'(pos) / 8;
        c = int'(pos) % 8;
        occ = pl[pos] | op[pos];
        if (!occ) begin
            for (int dr = -1; dr <= 1; dr++) begin
                for (int dc = -1; dc <= 1; dc++) begin
                    if (dr != 0 || dc != 0) begin
                        run = '0;
                        rr = r + dr;
                        cc = c + dc;
                        while (rr >= 0 && rr < 8 && cc >= 0 && cc < 8
                               && op[6'(rr*8+cc)]) begin
                            run[6'(rr*8+cc)] = 1'b1;
                            rr += dr;
                            cc += dc;
                        end
                        if (rr >= 0 && rr < 8 && cc >= 0 && cc < 8
                            && pl[6'(rr*8+cc)])
                            flip |= run;
                    end
                end
            end
        end
        legal = (flip != 0);
        npl = legal ? (pl | flip | (64'd1 << pos)) : pl;
        nop = legal ? (op & ~flip) : op;
    endfunction

    function automatic beat_t expect_of(input in_beat_t b);
        beat_t e;
        logic [63:0] f, np, no;
        logic lg, oc;
        e.tag = b.tag;
        e.en = b.en;
        e.flip = '0; e.npl = '0; e.nop = '0; e.legal = '0; e.occ = '0;
        for (int k = 0; k < 2; k++) begin
            ref_lane(b.en[k], b.pl[64*k +: 64], b.op[64*k +: 64],
                     b.pos[6*k +: 6], f, lg, oc, np, no);
            e.flip[64*k +: 64] = f;
            e.npl[64*k +: 64] = np;
            e.nop[64*k +: 64] = no;
            e.legal[k] = lg;
            e.occ[k] = oc;
        end
        return e;
    endfunction

    function automatic in_beat_t rand_beat(input logic [7:0] tag);
        in_beat_t b;
        logic [63:0] p;
        b.tag = tag;
        b.en = 2'($urandom_range(0, 3));
        b.pl = '0; b.op = '0;
        for (int k = 0; k < 2; k++) begin
            p = rand64() & rand64();
            b.pl[64*k +: 64] = p;
            b.op[64*k +: 64] = rand64() & ~p;
        end
        b.pos = 12'($urandom);
        return b;
    endfunction

    // Called just after a rising edge; returns just after the accept edge
    task automatic send(input in_beat_t b);
        int n;
        logic ok;
        in_valid = 1'b1;
        in_lane_en = b.en;
        in_player = b.pl;
        in_opponent = b.op;
        in_pos = b.pos;
        in_tag = b.tag;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 60) begin
            @(negedge clock);
            if (in_ready) ok = 1'b1;
            else begin
                @(posedge clock);
                #1;
                n++;
            end
        end
        if (ok) begin
            exp_q.push_back(expect_of(b));
            @(posedge clock);
            #1;
        end else begin
            chk("send_timeout", 1'b0, 1'b1);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("drain_left", 128'(exp_q.size()), 128'd0);
        exp_q.delete();
    endtask

    // Output monitor: scoreboard on transfer, hold check across stalls
    logic         stall_prev = 1'b0;
    logic [7:0]   s_tag;
    logic [1:0]   s_en, s_lg, s_oc;
    logic [127:0] s_fl, s_pl, s_op;
    initial begin
        beat_t e;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                if (stall_prev) begin
                    checks++;
                    if (!out_valid || out_tag !== s_tag || out_flip !== s_fl
                        || out_player !== s_pl || out_opponent !== s_op
                        || out_legal !== s_lg || out_occupied !== s_oc
                        || out_lane_en !== s_en) begin
                        errors++;
                        $display("FAIL hold tag %h want %h valid %b",
                                 out_tag, s_tag, out_valid);
                    end
                end
                stall_prev = out_valid && !out_ready;
                s_tag = out_tag; s_fl = out_flip; s_pl = out_player;
                s_op = out_opponent; s_lg = out_legal;
                s_oc = out_occupied; s_en = out_lane_en;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected beat tag %h want none",
                                 out_tag);
                    end else begin
                        e = exp_q.pop_front();
                        chk("s_tag", out_tag, e.tag);
                        chk("s_en", out_lane_en, e.en);
                        chk("s_flip", out_flip, e.flip);
                        chk("s_legal", out_legal, e.legal);
                        chk("s_occ", out_occupied, e.occ);
                        chk("s_player", out_player, e.npl);
                        chk("s_opp", out_opponent, e.nop);
                    end
                end
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    initial begin
        in_beat_t b;
        int n;
        logic done;
        logic [63:0] ip, io;

        ip = 64'h0000_0008_1000_0000;
        io = 64'h0000_0010_0800_0000;
        vt[0] = '{ip, io, 6'd19, 64'h0000_0000_0800_0000, 1'b1, 1'b0,
                  64'h0000_0008_1808_0000, 64'h0000_0010_0000_0000};
        vt[1] = '{ip, io, 6'd0, 64'h0, 1'b0, 1'b0, ip, io};
        vt[2] = '{ip, io, 6'd27, 64'h0, 1'b0, 1'b1, ip, io};
        vt[3] = '{64'h1, 64'h0000_0000_0804_0200, 6'd36,
                  64'h0000_0000_0804_0200, 1'b1, 1'b0,
                  64'h0000_0010_0804_0201, 64'h0};
        vt[4] = '{64'h80, 64'h0000_0000_0020_4000, 6'd28,
                  64'h0000_0000_0020_4000, 1'b1, 1'b0,
                  64'h0000_0000_1020_4080, 64'h0};
        vt[5] = '{64'h100, 64'h80, 6'd6, 64'h0, 1'b0, 1'b0,
                  64'h100, 64'h80};
        vt[6] = '{64'h0, 64'h7e, 6'd0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h7e};
        vt[7] = '{64'h80, 64'h7e, 6'd0, 64'h7e, 1'b1, 1'b0,
                  64'hff, 64'h0};

        reset = 1'b1;
        in_valid = 1'b0;
        in_lane_en = '0;
        in_player = '0;
        in_opponent = '0;
        in_pos = '0;
        in_tag = '0;
        out_ready = 1'b1;

        repeat (3) begin
            @(posedge clock);
            #1;
        end
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_flip", out_flip, 128'd0);
        chk("rst_player", out_player, 128'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_in_ready", in_ready, 1'b1);
        @(posedge clock);
        #1;

        // Fixed vectors on lane 0, lane 1 disabled but fed junk
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_lane_en = 2'b01;
            in_player = {rand64(), vt[i].pl};
            in_opponent = {rand64(), vt[i].op};
            in_pos = {6'($urandom), vt[i].pos};
            in_tag = 8'(8'h40 + i);
            @(negedge clock);
            chk("v_in_ready", in_ready, 1'b1);
            @(posedge clock);
            #1;
            in_valid = 1'b0;
            n = 0;
            while (!out_valid && n < 10) begin
                @(posedge clock);
                #1;
                n++;
            end
            chk("v_latency", 128'(n), 128'd3);
            chk("v_tag", out_tag, 8'(8'h40 + i));
            chk("v_flip", out_flip[63:0], vt[i].flip);
            chk("v_legal", out_legal[0], vt[i].legal);
            chk("v_occ", out_occupied[0], vt[i].occ);
            chk("v_player", out_player[63:0], vt[i].npl);
            chk("v_opp", out_opponent[63:0], vt[i].nop);
            chk("v_en", out_lane_en, 2'b01);
            chk("v_l1_zero", {out_flip[127:64], out_player[127:64],
                out_opponent[127:64] != 64'd0, out_legal[1],
                out_occupied[1]}, 128'd0);
        end
        repeat (2) begin
            @(posedge clock);
            #1;
        end

        // Backpressure: four beats, then five stalled cycles
        mon_en = 1'b1;
        out_ready = 1'b0;
        fork
            begin
                for (int t = 1; t <= 4; t++) begin
                    b.tag = 8'(t);
                    b.en = 2'b11;
                    ip = rand64() & rand64();
                    b.pl = {ip, vt[t-1].pl};
                    b.op = {rand64() & ~ip, vt[t-1].op};
                    b.pos = {6'($urandom), vt[t-1].pos};
                    send(b);
                end
            end
            begin
                n = 0;
                @(negedge clock);
                while (!out_valid && n < 20) begin
                    @(negedge clock);
                    n++;
                end
                chk("bp_reach", out_valid, 1'b1);
                for (int i = 0; i < 5; i++) begin
                    chk("bp_in_ready", in_ready, 1'b0);
                    chk("bp_head_tag", out_tag, 8'd1);
                    if (i < 4) @(negedge clock);
                end
                @(posedge clock);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();
        repeat (4) begin
            @(posedge clock);
            #1;
        end

        // Reset while beats are in flight and one is on the output
        for (int t = 0; t < 4; t++) send(rand_beat(8'(8'h80 + t)));
        chk("mr_busy", busy, 1'b1);
        chk("mr_valid_before", out_valid, 1'b1);
        mon_en = 1'b0;
        reset = 1'b1;
        exp_q.delete();
        @(negedge clock);
        chk("mr_in_ready", in_ready, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("mr_out_valid", out_valid, 1'b0);
        chk("mr_busy_after", busy, 1'b0);
        chk("mr_data", {out_flip, out_tag}, 136'd0);
        mon_en = 1'b1;
        @(negedge clock);
        chk("mr_in_ready_after", in_ready, 1'b1);
        repeat (10) begin
            @(posedge clock);
            #1;
        end

        // Random traffic with random backpressure
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    n = $urandom_range(0, 2);
                    repeat (n) begin
                        @(posedge clock);
                        #1;
                    end
                    send(rand_beat(8'(i)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clock);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        wait_drain();
        repeat (5) begin
            @(posedge clock);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
